// File: rtl/up_pkg.sv
// -----------------------------------------------------------------------------
// up_pkg
// Shared constants for the 4-bit microprocessor (uP) datapath.
//   PC_WIDTH   : program counter / ROM address width (default for contador_12b)
//   PC_RESET   : value the program counter takes on reset
//   CTL_INCPC  : decode control-word bit that requests a PC increment
//   CTL_LOADPC : decode control-word bit that requests a PC load (jump)
// -----------------------------------------------------------------------------
package up_pkg;

  localparam int          PC_WIDTH   = 12;
  localparam logic [11:0] PC_RESET   = 12'h000;

  localparam int          CTL_INCPC  = 12;
  localparam int          CTL_LOADPC = 11;

  // Next-PC selection, listed in priority order (highest first).
  typedef enum logic [1:0] {
    PC_SEL_RESET = 2'd0,
    PC_SEL_LOAD  = 2'd1,
    PC_SEL_INC   = 2'd2,
    PC_SEL_HOLD  = 2'd3
  } pc_sel_e;

  // Resolve the fixed priority reset > load > enable > hold.
  function automatic pc_sel_e pc_select(input logic reset,
                                        input logic load,
                                        input logic enable);
    pc_sel_e sel;
    if (reset) begin
      sel = PC_SEL_RESET;
    end else if (load) begin
      sel = PC_SEL_LOAD;
    end else if (enable) begin
      sel = PC_SEL_INC;
    end else begin
      sel = PC_SEL_HOLD;
    end
    return sel;
  endfunction

endpackage : up_pkg

// File: rtl/contador_12b.sv
// -----------------------------------------------------------------------------
// contador_12b
// Program counter for the uP. Holds the current ROM address, increments on
// incPC and loads a jump target on loadPC. Q is purely registered.
//
// Ports (positional order as used in uP: load, enable, clk, reset, D, Q):
//   load   : loadPC, Q <= D at the next rising edge (beats enable)
//   enable : incPC, Q <= Q + 1 at the next rising edge when load is low
//   clk    : system clock, rising-edge active
//   reset  : synchronous, active-high; Q <= RESET_VALUE (beats load/enable)
//   D      : parallel load value (jump target {oprnd, program_byte})
//   Q      : current program counter
//   tc     : (only with CONTADOR_TC_EN) combinational terminal-count flag,
//            high when the next edge wraps Q from all ones to zero
//
// Build option: define CONTADOR_TC_EN to add the tc output.
// -----------------------------------------------------------------------------
module contador_12b
  import up_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
  input  logic             load,
  input  logic             enable,
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
`ifdef CONTADOR_TC_EN
  ,
  output logic             tc
`endif
);

  pc_sel_e          sel_s;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] q_r;

  // Next-state mux; the increment wraps modulo 2^WIDTH (carry discarded).
  always_comb begin
    sel_s    = pc_select(reset, load, enable);
    q_next_s = q_r;
    case (sel_s)
      PC_SEL_RESET: q_next_s = RESET_VALUE;
      PC_SEL_LOAD:  q_next_s = D;
      PC_SEL_INC:   q_next_s = q_r + WIDTH'(1);
      PC_SEL_HOLD:  q_next_s = q_r;
      default:      q_next_s = RESET_VALUE;
    endcase
  end

  // Program counter register; reset is handled inside the mux, so it is
  // only seen at a rising edge.
  always_ff @(posedge clk) begin
    q_r <= q_next_s;
  end

  assign Q = q_r;

`ifdef CONTADOR_TC_EN
  // Flags that an increment will happen this edge from the all-ones value.
  assign tc = ~reset & enable & ~load & (&q_r);
`endif

endmodule : contador_12b

// File: tb/tb_contador_12b.sv
// -----------------------------------------------------------------------------
// tb_contador_12b
// Table-driven bench for contador_12b. Each record is one clock edge worth of
// inputs with the Q expected after that edge. Inputs change on the falling
// edge; Q is sampled 1 time unit after it (must still hold the old value) and
// 1 time unit after the rising edge (must show the new value).
// Build option: define CONTADOR_TC_EN to also check tc.
// -----------------------------------------------------------------------------
module tb_contador_12b;

  localparam int W = 12;

  logic         clk;
  logic         reset;
  logic         load;
  logic         enable;
  logic [W-1:0] D;
  logic [W-1:0] Q;
`ifdef CONTADOR_TC_EN
  logic         tc;
`endif

  int checks;
  int errors;
  logic [W-1:0] exp_prev;

  contador_12b dut (
    .load   (load),
    .enable (enable),
    .clk    (clk),
    .reset  (reset),
    .D      (D),
    .Q      (Q)
`ifdef CONTADOR_TC_EN
    ,
    .tc     (tc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         r;
    logic         l;
    logic         e;
    logic [W-1:0] d;
    logic [W-1:0] q;
    string        name;
  } vec_t;

  vec_t vecs[$];

  task automatic check_q(input string name, input logic [W-1:0] exp);
    checks++;
    if (Q !== exp) begin
      errors++;
      $display("FAIL %s: Q got %h required %h", name, Q, exp);
    end
  endtask

  // One edge: drive on negedge, confirm no early change, check after posedge.
  task automatic step(input logic r, input logic l, input logic e,
                      input logic [W-1:0] d, input logic [W-1:0] exp,
                      input string name);
    @(negedge clk);
    reset  = r;
    load   = l;
    enable = e;
    D      = d;
    #1;
    if (exp_prev !== 'x) check_q({name, "_hold"}, exp_prev);
`ifdef CONTADOR_TC_EN
    if (exp_prev !== 'x) begin
      logic exp_tc;
      exp_tc = ~r & e & ~l & (exp_prev == {W{1'b1}});
      checks++;
      if (tc !== exp_tc) begin
        errors++;
        $display("FAIL %s_tc: tc got %b required %b", name, tc, exp_tc);
      end
    end
`endif
    @(posedge clk);
    #1;
    check_q(name, exp);
    exp_prev = exp;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_prev = 'x;
    reset    = 1'b0;
    load     = 1'b0;
    enable   = 1'b0;
    D        = 12'h000;

    //          r     l     e     D        Q after edge
    vecs.push_back('{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, "reset_init"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 12'h5A3, 12'h5A3, "load_5a3"});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 12'hFFF, 12'h000, "reset_over_all"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h777, 12'h001, "inc1"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h777, 12'h002, "inc2"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h777, 12'h003, "inc3"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h777, 12'h004, "inc4"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h777, 12'h005, "inc5"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 12'h777, 12'h005, "idle1"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 12'h777, 12'h005, "idle2"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 12'h777, 12'h005, "idle3"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 12'hABC, 12'hABC, "load_abc"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h000, 12'hABD, "inc_abd"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'hxxx, 12'hABE, "d_x_ignored"});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 12'h123, 12'h123, "load_beats_inc"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 12'hFFE, 12'hFFE, "load_ffe"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h000, 12'hFFF, "inc_fff"});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 12'h000, 12'h000, "wrap"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 12'hFFF, 12'hFFF, "load_fff"});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 12'h456, 12'h456, "load_at_fff"});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 12'hFFF, 12'hFFF, "load_fff2"});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 12'h000, 12'hFFF, "hold_fff"});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 12'h000, 12'h000, "reset_at_fff"});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].l, vecs[i].e, vecs[i].d, vecs[i].q, vecs[i].name);
    end

    // Reset pulse that covers no rising edge must not disturb Q.
    step(1'b0, 1'b1, 1'b0, 12'h321, 12'h321, "load_321");
    @(negedge clk);
    load   = 1'b0;
    enable = 1'b0;
    #1;
    reset  = 1'b1;
    #1;
    check_q("glitch_reset_during", 12'h321);
    #1;
    reset  = 1'b0;
    @(posedge clk);
    #1;
    check_q("glitch_reset_after_edge", 12'h321);

    // Reset held across an edge, then dropped mid-cycle: Q stays 0 until the
    // following edge, then counts from 0.
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    check_q("reset_with_enable", 12'h000);
    #2;
    reset  = 1'b0;
    #1;
    check_q("reset_drop_midcycle", 12'h000);
    @(posedge clk);
    #1;
    check_q("count_after_reset", 12'h001);
    enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_contador_12b

// File: doc/contador_12b.md
Name: contador_12b

Overview:
- 12-bit program counter for the 4-bit microprocessor (uP).
- Holds the current ROM address (PC). Increments by one on incPC, or loads a 12-bit jump target (address_RAM = {oprnd, program_byte}) on loadPC.
- Driven by decode control bits: bit 12 = incPC (enable), bit 11 = loadPC (load).
- Output feeds the program ROM address directly.

Parameters:
- WIDTH, 12, counter and load-data width in bits.
- RESET_VALUE, 0, value Q takes on reset.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  loadPC; when high, Q takes D at the next rising edge.
- enable  input  1  incPC; when high and load is low, Q increments at the next rising edge.
- D  input  WIDTH  parallel load value (jump target).
- Q  output  WIDTH  current count / program counter.
- Positional order as instantiated in uP: load, enable, clk, reset, D, Q.

Behaviour:
- Single register Q, updated only on the rising edge of clk.
- Priority at each rising edge, highest first:
  - reset=1: Q <= RESET_VALUE (0x000).
  - load=1: Q <= D.
  - enable=1: Q <= Q + 1.
  - Otherwise Q holds its value.
- Reset is synchronous. Asserting reset between edges has no effect until the next rising edge. Reset overrides load and enable in the same cycle.
- Simultaneous load=1 and enable=1: load wins and Q <= D, with no increment. The decode table never drives both, but the priority is still fixed.
- Wrap-around: Q = 0xFFF with enable=1 gives Q = 0x000 at the next edge. No flag in the base build.
- Increment is modulo 2^WIDTH, unsigned. The carry out of bit WIDTH-1 is discarded.
- Latency: one clock from load/enable sampled to Q updated. Q is a registered output with no combinational path from any input.
- X/Z on D is ignored unless load=1.
- At power-up before the first reset, Q is undefined. The bench must apply reset first.
- In uP, incPC and loadPC are sampled every clock. The phase flip-flop gates them through decode (phase bit 0 forces incPC=1 during fetch).

Optional Feature:
- Macro: CONTADOR_TC_EN.
- Defined: adds output tc (1 bit, combinational) = enable & ~load & (Q == all ones). It flags that the next edge wraps to 0. tc is 0 during reset cycles only if reset is applied as a gating term; implement tc = ~reset & enable & ~load & (&Q).
- Undefined: tc port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package up_pkg holds:
  - PC_WIDTH = 12 (default for WIDTH).
  - PC_RESET = 12'h000.
  - Decode control-bit index constants: CTL_INCPC = 12, CTL_LOADPC = 11.
- No sub-module is needed. A next-state mux plus one WIDTH-bit register in a single module is the natural form.
- The uP top connects ctl[CTL_LOADPC] to load and ctl[CTL_INCPC] to enable.

Test Plan:
- Reset: Q=0x5A3, assert reset for one edge with load=1, enable=1 -> Q=0x000. Drop reset mid-cycle -> Q holds until the next edge.
- Increment: from 0x000 with enable=1 for 5 edges -> Q = 1,2,3,4,5. Set enable=0 for 3 edges -> Q stays 0x005.
- Load: D=0xABC, load=1, one edge -> Q=0xABC. Then enable=1, one edge -> Q=0xABD.
- Priority: load=1, enable=1, D=0x123 -> Q=0x123, not incremented.
- Wrap: load D=0xFFE, then enable=1 for 2 edges -> Q=0xFFF, then 0x000. With CONTADOR_TC_EN defined, tc=1 only while Q=0xFFF and enable=1, load=0.
- Synchronous reset check: pulse reset between two edges without covering an edge -> Q is unchanged.
